// File: rtl/sample_playback_if.sv
// sample_playback_if: single-outstanding read port between the playback engine and sample memory.
interface sample_playback_if #(
    parameter int ADDR_W = 27,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd_req;
    logic              mem_rd_valid;
    logic [DATA_W-1:0] mem_rd_data;
    modport master (output mem_addr, mem_rd_req, input mem_rd_valid, mem_rd_data);
    modport slave (input mem_addr, mem_rd_req, output mem_rd_valid, mem_rd_data);
endinterface

// File: rtl/sample_playback.sv
// sample_playback: streams a length-prefixed sample from memory, one word per sample_tick.
module sample_playback #(
    parameter int ADDR_W = 27,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] address_in,
    input  logic              trigger_playback,
    input  logic              sample_tick,
    sample_playback_if.master mem,
    output logic [DATA_W-1:0] audio_out,
    output logic              playing,
    output logic              done,
    output logic              underrun
);
    localparam logic [2:0] IDLE = 3'd0, HDR = 3'd1, FETCH = 3'd2, READY = 3'd3, DRAIN = 3'd4;
    logic [2:0]        state;
    logic              trig_q;
    logic              outstanding;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] rd_ptr;
    logic [15:0]       remaining;
    logic [DATA_W-1:0] word_buf;
    logic              edge_hit;
    logic              retrig;
    logic              starved;
    assign edge_hit = trigger_playback & ~trig_q;
    assign retrig   = edge_hit && state != IDLE;
    assign starved  = state == HDR || state == FETCH || state == DRAIN;
    // trig_q resets high so a trigger already high at reset release is not an edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            trig_q         <= 1'b1;
            outstanding    <= 1'b0;
            base           <= '0;
            rd_ptr         <= '0;
            remaining      <= '0;
            word_buf       <= '0;
            mem.mem_addr   <= '0;
            mem.mem_rd_req <= 1'b0;
            audio_out      <= '0;
            playing        <= 1'b0;
            done           <= 1'b0;
            underrun       <= 1'b0;
        end else begin
            trig_q         <= trigger_playback;
            mem.mem_rd_req <= 1'b0;
            done           <= 1'b0;
            underrun       <= sample_tick && playing && starved && !edge_hit;
            if (mem.mem_rd_valid) outstanding <= 1'b0;
            if (retrig) begin
                base <= address_in;
                if (outstanding && !mem.mem_rd_valid) state <= DRAIN;
                else begin
                    mem.mem_rd_req <= 1'b1;
                    mem.mem_addr   <= address_in;
                    outstanding    <= 1'b1;
                    state          <= HDR;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (sample_tick) audio_out <= '0;
                        if (edge_hit) begin
                            base           <= address_in;
                            playing        <= 1'b1;
                            mem.mem_rd_req <= 1'b1;
                            mem.mem_addr   <= address_in;
                            outstanding    <= 1'b1;
                            state          <= HDR;
                        end
                    end
                    HDR: if (mem.mem_rd_valid) begin
                        if (mem.mem_rd_data == '0) begin
                            done    <= 1'b1;
                            playing <= 1'b0;
                            state   <= IDLE;
                        end else begin
                            remaining      <= 16'(mem.mem_rd_data);
                            rd_ptr         <= base + 1'b1;
                            mem.mem_rd_req <= 1'b1;
                            mem.mem_addr   <= base + 1'b1;
                            outstanding    <= 1'b1;
                            state          <= FETCH;
                        end
                    end
                    FETCH: if (mem.mem_rd_valid) begin
                        word_buf <= mem.mem_rd_data;
                        rd_ptr   <= rd_ptr + 1'b1;
                        state    <= READY;
                    end
                    READY: if (sample_tick) begin
                        audio_out <= word_buf;
                        remaining <= remaining - 1'b1;
                        if (remaining == 16'd1) begin
                            done    <= 1'b1;
                            playing <= 1'b0;
                            state   <= IDLE;
                        end else begin
                            mem.mem_rd_req <= 1'b1;
                            mem.mem_addr   <= rd_ptr;
                            outstanding    <= 1'b1;
                            state          <= FETCH;
                        end
                    end
                    DRAIN: if (mem.mem_rd_valid) begin
                        mem.mem_rd_req <= 1'b1;
                        mem.mem_addr   <= base;
                        outstanding    <= 1'b1;
                        state          <= HDR;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_sample_playback.sv
// tb_sample_playback: table-driven and randomized playback scenarios against a memory-image reference model.
module tb_sample_playback;
    localparam int AW = 27, DW = 16;
    typedef logic [AW-1:0] addr_t;
    typedef struct {
        addr_t       base;
        int          len;
        int          lat;
        int          period;
        logic [15:0] step;
        int          exp_done;
        int          exp_ur;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          trigger_playback = 1'b0;
    logic          sample_tick = 1'b0;
    addr_t         address_in = '0;
    logic [DW-1:0] audio_out;
    logic          playing, done, underrun;

    sample_playback_if #(.ADDR_W(AW), .DATA_W(DW)) m ();
    sample_playback #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset_n(reset_n), .address_in(address_in),
        .trigger_playback(trigger_playback), .sample_tick(sample_tick), .mem(m.master),
        .audio_out(audio_out), .playing(playing), .done(done), .underrun(underrun)
    );

    always #5 clk = ~clk;

    logic [15:0] mem_words [addr_t];
    int n_chk = 0, n_pass = 0;
    int cyc = 0, period = 0, lat = 2, cnt = 0, trig_cyc = 0;
    bit tick_d = 1'b0;
    addr_t pend;
    logic [15:0] got_words [$];
    addr_t reads [$];
    int done_cnt, underrun_cnt, hold_bad, idle_nonzero, idle_ticks, play_after_done, first_req_cyc;
    logic [15:0] done_word, prev_audio;
    vec_t vecs [5];
    addr_t eq [$];
    logic [15:0] ew [$];
    addr_t rb;
    int rl, rlat, rp;

    function automatic logic [15:0] rd(input addr_t a);
        return mem_words.exists(a) ? mem_words[a] : 16'hDEAD;
    endfunction

    // monitor, memory model and tick source share one process so their ordering is fixed
    always @(negedge clk) begin
        cyc++;
        if (reset_n) begin
            if (tick_d) begin
                if (underrun) hold_bad += int'(audio_out != prev_audio);
                else if (playing || done) got_words.push_back(audio_out);
                else begin
                    idle_ticks++;
                    idle_nonzero += int'(audio_out != 16'h0);
                end
            end
            if (done) begin
                done_cnt++;
                done_word = audio_out;
            end
            if (playing && done_cnt > 0) play_after_done++;
            if (underrun) underrun_cnt++;
            if (m.mem_rd_req) begin
                if (reads.size() == 0) first_req_cyc = cyc;
                reads.push_back(m.mem_addr);
            end
        end
        prev_audio = audio_out;
        m.mem_rd_valid = 1'b0;
        if (!reset_n) cnt = 0;
        else begin
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    m.mem_rd_valid = 1'b1;
                    m.mem_rd_data = rd(pend);
                end
            end
            if (m.mem_rd_req) begin
                pend = m.mem_addr;
                cnt = lat;
            end
        end
        tick_d = period > 0 && cyc % period == 0;
        sample_tick = tick_d;
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic clear_rec();
        got_words.delete();
        reads.delete();
        done_cnt = 0; underrun_cnt = 0; hold_bad = 0; idle_nonzero = 0;
        idle_ticks = 0; play_after_done = 0; first_req_cyc = -1;
    endtask

    task automatic fill(input addr_t b, input int len, input logic [15:0] step);
        mem_words[b] = 16'(len);
        for (int k = 1; k <= len; k++)
            mem_words[addr_t'(b + k)] = step != 16'h0 ? 16'(step * k) : 16'($urandom);
    endtask

    task automatic start(input addr_t a, input bit align);
        if (align && period > 0) do begin @(negedge clk); #1; end while (!sample_tick);
        do begin @(negedge clk); #1; end while (sample_tick);
        address_in = a;
        trigger_playback = 1'b1;
        trig_cyc = cyc;
    endtask

    task automatic wait_done(input string name, input int budget);
        int i = 0;
        while (done_cnt == 0 && i < budget) begin
            @(negedge clk);
            i++;
        end
        #1 check({name, "_finished"}, 64'(done_cnt > 0), 64'd1);
    endtask

    task automatic cmp_reads(input string name, input addr_t exp [$]);
        check({name, "_nreads"}, 64'(reads.size()), 64'(exp.size()));
        foreach (exp[i]) if (i < reads.size()) check($sformatf("%s_read%0d", name, i), 64'(reads[i]), 64'(exp[i]));
    endtask

    task automatic cmp_words(input string name, input logic [15:0] exp [$]);
        check({name, "_nwords"}, 64'(got_words.size()), 64'(exp.size()));
        foreach (exp[i]) if (i < got_words.size()) check($sformatf("%s_word%0d", name, i), 64'(got_words[i]), 64'(exp[i]));
    endtask

    task automatic run_vec(input string name, input addr_t base, input int len, input int l, input int p,
                           input int exp_done, input int exp_ur);
        addr_t xr [$];
        logic [15:0] xw [$];
        lat = l;
        period = p;
        for (int k = 0; k <= len; k++) xr.push_back(addr_t'(base + k));
        for (int k = 1; k <= len; k++) xw.push_back(rd(addr_t'(base + k)));
        clear_rec();
        start(base, 1'b1);
        repeat (2) @(negedge clk);
        trigger_playback = 1'b0;
        wait_done(name, 4000);
        repeat (p + 4) @(negedge clk);
        #1;
        check({name, "_req_latency"}, 64'(first_req_cyc), 64'(trig_cyc + 1));
        cmp_reads(name, xr);
        cmp_words(name, xw);
        check({name, "_done"}, 64'(done_cnt), 64'(exp_done));
        if (exp_ur >= 0) check({name, "_underrun"}, 64'(underrun_cnt > 0), 64'(exp_ur));
        check({name, "_hold"}, 64'(hold_bad), 64'd0);
        check({name, "_idle_zero"}, 64'(idle_nonzero), 64'd0);
        check({name, "_idle_tick"}, 64'(idle_ticks > 0), 64'd1);
        if (len > 0) check({name, "_done_word"}, 64'(done_word), 64'(xw[len-1]));
        check({name, "_play_after_done"}, 64'(play_after_done), 64'd0);
        check({name, "_playing_end"}, 64'(playing), 64'd0);
    endtask

    initial begin
        vecs[0] = '{27'h100, 3, 2, 20, 16'h1111, 1, 0};
        vecs[1] = '{27'h200, 0, 2, 20, 16'h0, 1, 0};
        vecs[2] = '{27'h400, 5, 30, 10, 16'h0, 1, 1};
        vecs[3] = '{27'h7FFFFFE, 2, 1, 8, 16'h0, 1, 0};
        vecs[4] = '{27'h500, 4, 1, 4, 16'h0101, 1, -1};
        clear_rec();
        repeat (3) @(negedge clk);
        #1;
        check("rst_audio", 64'(audio_out), 64'd0);
        check("rst_playing", 64'(playing), 64'd0);
        check("rst_req", 64'(m.mem_rd_req), 64'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        foreach (vecs[i]) begin
            fill(vecs[i].base, vecs[i].len, vecs[i].step);
            run_vec($sformatf("vec%0d", i), vecs[i].base, vecs[i].len, vecs[i].lat, vecs[i].period,
                    vecs[i].exp_done, vecs[i].exp_ur);
        end
        for (int r = 0; r < 4; r++) begin
            rb = addr_t'($urandom);
            rl = $urandom_range(1, 6);
            rlat = $urandom_range(1, 6);
            rp = $urandom_range(3, 14);
            fill(rb, rl, 16'h0);
            run_vec($sformatf("rnd%0d", r), rb, rl, rlat, rp, 1, -1);
        end
        // retrigger while the first data read is in flight
        fill(27'h300, 1, 16'h0);
        mem_words[27'h301] = 16'h7FFF;
        lat = 6;
        period = 40;
        clear_rec();
        start(27'h100, 1'b1);
        repeat (2) @(negedge clk);
        trigger_playback = 1'b0;
        for (int i = 0; i < 60 && reads.size() < 2; i++) @(negedge clk);
        check("retrig_fetch_reached", 64'(reads.size()), 64'd2);
        start(27'h300, 1'b0);
        repeat (2) @(negedge clk);
        trigger_playback = 1'b0;
        wait_done("retrig", 2000);
        repeat (45) @(negedge clk);
        #1;
        eq.delete();
        eq.push_back(27'h100); eq.push_back(27'h101); eq.push_back(27'h300); eq.push_back(27'h301);
        ew.delete();
        ew.push_back(16'h7FFF);
        cmp_reads("retrig", eq);
        cmp_words("retrig", ew);
        check("retrig_done", 64'(done_cnt), 64'd1);
        check("retrig_hold", 64'(hold_bad), 64'd0);
        // held trigger plays exactly once
        lat = 2;
        period = 20;
        clear_rec();
        start(27'h100, 1'b1);
        repeat (500) @(negedge clk);
        #1 trigger_playback = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        check("held_done", 64'(done_cnt), 64'd1);
        check("held_reads", 64'(reads.size()), 64'd4);
        check("held_words", 64'(got_words.size()), 64'd3);
        // async reset mid-fetch, released with trigger still high
        lat = 30;
        period = 10;
        mem_words[27'h401] = 16'h1234;
        clear_rec();
        start(27'h400, 1'b1);
        for (int i = 0; i < 400 && reads.size() < 3; i++) @(negedge clk);
        #1;
        check("pre_reset_playing", 64'(playing), 64'd1);
        check("pre_reset_audio", 64'(audio_out), 64'h1234);
        reset_n = 1'b0;
        #1;
        check("arst_audio", 64'(audio_out), 64'd0);
        check("arst_addr", 64'(m.mem_addr), 64'd0);
        check("arst_req", 64'(m.mem_rd_req), 64'd0);
        check("arst_playing", 64'(playing), 64'd0);
        check("arst_done", 64'(done), 64'd0);
        check("arst_underrun", 64'(underrun), 64'd0);
        repeat (3) @(negedge clk);
        #1 reset_n = 1'b1;
        clear_rec();
        repeat (200) @(negedge clk);
        #1;
        check("post_reset_reads", 64'(reads.size()), 64'd0);
        check("post_reset_playing", 64'(playing), 64'd0);
        trigger_playback = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_chk);
        $fatal(1);
    end
endmodule
